// File: rtl/masked_cam.sv
// Masked-key content-addressable memory with a 1-cycle registered search
// response, valid/ready handshaking and an optional pop-on-hit.
module masked_cam #(
   parameter int CAM_DW = 32,
   parameter int CAM_KW = 3,
   parameter int CAM_AW = 4,
   parameter int POP_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [CAM_AW-1:0] wr_addr,
   input  logic [CAM_DW-1:0] wr_data,
   input  logic              inv_en,
   input  logic [CAM_AW-1:0] inv_addr,
   input  logic              srch_valid,
   output logic              srch_ready,
   input  logic [CAM_KW-1:0] srch_key,
   input  logic [CAM_KW-1:0] srch_mask,
   input  logic              srch_pop,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_hit,
   output logic              rsp_multi,
   output logic [CAM_AW-1:0] rsp_addr,
   output logic [CAM_DW-1:0] rsp_data,
   output logic [CAM_AW:0]   entry_cnt,
   output logic              full
);

   localparam int unsigned DEPTH = 2**CAM_AW;

   logic [CAM_DW-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  occ;
   logic [DEPTH-1:0]  occ_next;
   logic [CAM_AW:0]   cnt_next;
   logic              accept;
   logic              hit;
   logic              multi;
   logic [CAM_AW-1:0] hit_addr;
   logic              pop_fire;
   logic              inc;
   logic              dec_inv;
   logic              dec_pop;

   assign srch_ready = !rsp_valid || rsp_ready;
   assign accept     = srch_valid && srch_ready;
   assign full       = (entry_cnt == (CAM_AW+1)'(DEPTH));

   // Ascending scan: the first match found is the lowest index.
   always_comb begin
      hit      = 1'b0;
      multi    = 1'b0;
      hit_addr = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (occ[i] && (((mem[i][CAM_DW-1 -: CAM_KW] ^ srch_key) & srch_mask) == '0)) begin
            if (hit) begin
               multi = 1'b1;
            end else begin
               hit      = 1'b1;
               hit_addr = CAM_AW'(i);
            end
         end
      end
   end

   assign pop_fire = (POP_EN != 0) && accept && srch_pop && hit;

   // Clears applied before the write so write > invalidate > pop on one index;
   // each decrement is suppressed when a higher-priority op owns that index.
   always_comb begin
      occ_next = occ;
      if (pop_fire) occ_next[hit_addr] = 1'b0;
      if (inv_en)   occ_next[inv_addr] = 1'b0;
      if (wr_en)    occ_next[wr_addr]  = 1'b1;
      inc      = wr_en && !occ[wr_addr];
      dec_inv  = inv_en && occ[inv_addr] && !(wr_en && (wr_addr == inv_addr));
      dec_pop  = pop_fire && !(wr_en && (wr_addr == hit_addr))
                          && !(inv_en && (inv_addr == hit_addr));
      cnt_next = entry_cnt + (CAM_AW+1)'(inc)
                           - (CAM_AW+1)'(dec_inv)
                           - (CAM_AW+1)'(dec_pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= '0;
         entry_cnt <= '0;
      end else begin
         occ       <= occ_next;
         entry_cnt <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_multi <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_hit   <= hit;
         rsp_multi <= multi;
         rsp_addr  <= hit_addr;
         rsp_data  <= hit ? mem[hit_addr] : '0;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_masked_cam.sv
// Self-checking bench for masked_cam: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the CAM.
module tb_masked_cam;

   localparam int DW    = 32;
   localparam int KW    = 3;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          inv_en;
   logic [AW-1:0] inv_addr;
   logic          srch_valid;
   logic          srch_ready;
   logic [KW-1:0] srch_key;
   logic [KW-1:0] srch_mask;
   logic          srch_pop;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_hit;
   logic          rsp_multi;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic [AW:0]   entry_cnt;
   logic          full;

   always #5 clk = ~clk;

   masked_cam #(.CAM_DW(DW), .CAM_KW(KW), .CAM_AW(AW), .POP_EN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .inv_en(inv_en), .inv_addr(inv_addr),
      .srch_valid(srch_valid), .srch_ready(srch_ready),
      .srch_key(srch_key), .srch_mask(srch_mask), .srch_pop(srch_pop),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hit(rsp_hit), .rsp_multi(rsp_multi),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .entry_cnt(entry_cnt), .full(full)
   );

   // reference model state
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_occ [DEPTH];
   bit            m_valid, m_hit, m_multi;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += m_occ[i];
      return c;
   endfunction

   task automatic m_search(input logic [KW-1:0] key, input logic [KW-1:0] mask,
                           output bit h, output bit mu, output logic [AW-1:0] a,
                           output logic [DW-1:0] d);
      int q[$];
      logic [KW-1:0] k;
      for (int i = 0; i < DEPTH; i++) begin
         k = m_mem[i][DW-1 -: KW];
         if (m_occ[i] && (((k ^ key) & mask) == 0)) q.push_back(i);
      end
      h  = (q.size() > 0);
      mu = (q.size() > 1);
      a  = h ? AW'(q[0]) : '0;
      d  = h ? m_mem[q[0]] : '0;
   endtask

   task automatic idle();
      wr_en = 0; inv_en = 0; srch_valid = 0; srch_pop = 0;
      wr_addr = '0; wr_data = '0; inv_addr = '0; srch_key = '0; srch_mask = '0;
   endtask

   task automatic check_outputs();
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_hit",   rsp_hit,   m_hit);
      check("rsp_multi", rsp_multi, m_multi);
      check("rsp_addr",  rsp_addr,  m_addr);
      check("rsp_data",  rsp_data,  m_rdata);
      check("entry_cnt", entry_cnt, m_count());
      check("full",      full,      m_count() == DEPTH);
   endtask

   // One clock: inputs are already driven (posedge+1); model advances at posedge.
   task automatic cycle();
      bit acc, h, mu;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(negedge clk);
      check("srch_ready", srch_ready, !m_valid || rsp_ready);
      acc = srch_valid && (!m_valid || rsp_ready);
      if (acc) m_search(srch_key, srch_mask, h, mu, a, d);
      @(posedge clk);
      if (acc) begin
         m_valid = 1; m_hit = h; m_multi = mu; m_addr = a; m_rdata = d;
         if (srch_pop && h) m_occ[a] = 0;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      if (inv_en) m_occ[inv_addr] = 0;
      if (wr_en) begin
         m_mem[wr_addr] = wr_data;
         m_occ[wr_addr] = 1;
      end
      #1;
      check_outputs();
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_occ[i] = 0;
      m_valid = 0; m_hit = 0; m_multi = 0; m_addr = '0; m_rdata = '0;
   endtask

   // Asserted between edges; response side checked while reset is held.
   task automatic do_reset();
      idle();
      rst_n = 0;
      #1;
      model_reset();
      check("rst_srch_ready", srch_ready, 1'b1);
      check_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int a, input logic [DW-1:0] d);
      idle(); rsp_ready = 1;
      wr_en = 1; wr_addr = AW'(a); wr_data = d;
      cycle();
   endtask

   task automatic do_search(input logic [KW-1:0] k, input logic [KW-1:0] m, input bit pop);
      idle(); rsp_ready = 1;
      srch_valid = 1; srch_key = k; srch_mask = m; srch_pop = pop;
      cycle();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      rsp_ready = 1;
      idle();
      rst_n = 1;
      #2;
      do_reset();

      // single write then exact-key search
      do_write(3, 32'hA000_0001);
      do_search(3'd5, 3'd7, 0);
      check("d1_hit", rsp_hit, 1'b1);
      check("d1_addr", rsp_addr, 4'd3);
      check("d1_data", rsp_data, 32'hA000_0001);
      check("d1_cnt", entry_cnt, 5'd1);

      // multi-match, then pop twice, then miss
      do_reset();
      do_write(2, 32'hA000_0002);
      do_write(9, 32'h8000_0009);
      do_search(3'd4, 3'd6, 0);
      check("d2_multi", rsp_multi, 1'b1);
      check("d2_addr", rsp_addr, 4'd2);
      do_search(3'd4, 3'd6, 1);
      check("d2_pop1_addr", rsp_addr, 4'd2);
      check("d2_pop1_cnt", entry_cnt, 5'd1);
      do_search(3'd4, 3'd6, 1);
      check("d2_pop2_addr", rsp_addr, 4'd9);
      check("d2_pop2_cnt", entry_cnt, 5'd0);
      do_search(3'd4, 3'd6, 0);
      check("d2_miss", rsp_hit, 1'b0);

      // stall with searches pending, then back-to-back
      do_write(1, 32'h2000_0001);
      idle(); rsp_ready = 0; srch_valid = 1; srch_key = 3'd1; srch_mask = 3'd7;
      repeat (4) cycle();
      check("d3_stall_ready", srch_ready, 1'b0);
      rsp_ready = 1;
      repeat (3) cycle();
      check("d3_b2b_ready", srch_ready, 1'b1);

      // write/invalidate/pop on entry 5 in one cycle; search sees old contents
      do_reset();
      do_write(5, 32'hC000_0005);
      idle(); rsp_ready = 1;
      wr_en = 1; wr_addr = 4'd5; wr_data = 32'h2000_0055;
      inv_en = 1; inv_addr = 4'd5;
      srch_valid = 1; srch_key = 3'd6; srch_mask = 3'd7; srch_pop = 1;
      cycle();
      check("d4_old_data", rsp_data, 32'hC000_0005);
      check("d4_cnt", entry_cnt, 5'd1);
      do_search(3'd1, 3'd7, 0);
      check("d4_new_data", rsp_data, 32'h2000_0055);

      // fill to full, then invalidate one
      for (int i = 0; i < DEPTH; i++) do_write(i, {3'(i % 8), 29'(i * 7 + 1)});
      check("d5_full", full, 1'b1);
      check("d5_cnt16", entry_cnt, 5'd16);
      idle(); inv_en = 1; inv_addr = 4'd0;
      cycle();
      check("d5_notfull", full, 1'b0);
      check("d5_cnt15", entry_cnt, 5'd15);

      // reset during a stalled hit response
      idle(); rsp_ready = 0; srch_valid = 1; srch_key = 3'd2; srch_mask = 3'd7;
      cycle();
      srch_valid = 0;
      cycle();
      check("d6_stalled", rsp_valid, 1'b1);
      do_reset();
      check("d6_valid0", rsp_valid, 1'b0);
      do_search(3'd2, 3'd7, 0);
      check("d6_miss", rsp_hit, 1'b0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         wr_en      = ($urandom_range(0, 9) < 4);
         wr_addr    = AW'($urandom);
         wr_data    = $urandom;
         inv_en     = ($urandom_range(0, 9) < 2);
         inv_addr   = AW'($urandom);
         srch_valid = ($urandom_range(0, 9) < 6);
         srch_key   = KW'($urandom);
         srch_mask  = KW'($urandom);
         srch_pop   = ($urandom_range(0, 9) < 3);
         rsp_ready  = ($urandom_range(0, 9) < 7);
         cycle();
      end

      idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
